// File: rtl/interfaz_tx_pkg.sv
// rtl/interfaz_tx_pkg.sv - shared UART glue constants: FSM encoding and default data width
package interfaz_tx_pkg;

  localparam int NB_DATA_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    BUSY  = 2'b10
  } state_e;

endpackage

// File: rtl/interfaz_tx.sv
// rtl/interfaz_tx.sv - ALU-to-UART-TX glue: latches results, fires a one-cycle start pulse,
// and holds one pending result while a byte is in flight
module interfaz_tx
  import interfaz_tx_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_resultado,
  input  logic               i_done_alu,
  input  logic               i_done_tx,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_int_tx
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               int_tx_q, int_tx_d;
  logic               pend_valid_q, pend_valid_d;
  logic [NB_DATA-1:0] pend_data_q, pend_data_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      int_tx_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      int_tx_q     <= int_tx_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_done_alu) state_d = START;
      START:   state_d = BUSY;
      BUSY: begin
        if (i_done_tx) begin
          state_d = (pend_valid_q || i_done_alu) ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // o_data only moves on the same edge that raises the start pulse
  always_comb begin
    data_d       = data_q;
    int_tx_d     = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    case (state_q)
      IDLE: begin
        if (i_done_alu) begin
          data_d   = i_resultado;
          int_tx_d = 1'b1;
        end
      end
      START: begin
        if (i_done_alu) begin
          pend_data_d  = i_resultado;
          pend_valid_d = 1'b1;
        end
      end
      BUSY: begin
        if (i_done_tx) begin
          if (pend_valid_q) begin
            data_d       = pend_data_q;
            int_tx_d     = 1'b1;
            pend_valid_d = i_done_alu;
            if (i_done_alu) pend_data_d = i_resultado;
          end else if (i_done_alu) begin
            data_d   = i_resultado;
            int_tx_d = 1'b1;
          end
        end else if (i_done_alu) begin
          // latest result wins over an older pending one
          pend_data_d  = i_resultado;
          pend_valid_d = 1'b1;
        end
      end
      default: begin
        int_tx_d     = 1'b0;
        pend_valid_d = 1'b0;
      end
    endcase
  end

  assign o_data   = data_q;
  assign o_int_tx = int_tx_q;

endmodule

// File: tb/tb_interfaz_tx.sv
// tb/tb_interfaz_tx.sv - self-checking bench for interfaz_tx with an expected-byte scoreboard
module tb_interfaz_tx;

  logic       i_clk;
  logic       i_rst;
  logic [7:0] i_resultado;
  logic       i_done_alu;
  logic       i_done_tx;
  logic [7:0] o_data;
  logic       o_int_tx;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pushes = 0;
  logic [7:0] exp_q[$];
  logic prev_int = 1'b0;

  interfaz_tx #(.NB_DATA(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_resultado(i_resultado),
    .i_done_alu (i_done_alu),
    .i_done_tx  (i_done_tx),
    .o_data     (o_data),
    .o_int_tx   (o_int_tx)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
    pushes++;
  endtask

  // Inputs are set between edges and cleared just after the sampling edge.
  task automatic drive(input logic alu, input logic [7:0] res, input logic tx);
    @(negedge i_clk);
    #1;
    i_done_alu  = alu;
    i_resultado = res;
    i_done_tx   = tx;
    @(posedge i_clk);
    #1;
    i_done_alu = 1'b0;
    i_done_tx  = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_int_tx === 1'b1) begin
        pulses++;
        if (prev_int) check("pulse_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {24'd0, o_data}, 32'hFFFF_FFFF);
        end else begin
          check("sb_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
        end
      end
      prev_int = (o_int_tx === 1'b1);
    end else begin
      prev_int = 1'b0;
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst       = 1'b1;
    i_resultado = 8'h00;
    i_done_alu  = 1'b0;
    i_done_tx   = 1'b0;

    // reset with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      i_resultado = 8'($urandom);
      i_done_alu  = 1'($urandom);
      i_done_tx   = 1'($urandom);
      @(posedge i_clk);
      #1;
      check("rst_data", {24'd0, o_data}, 32'h00);
      check("rst_int", {31'd0, o_int_tx}, 32'd0);
    end
    @(negedge i_clk);
    i_done_alu = 1'b0;
    i_done_tx  = 1'b0;
    i_rst      = 1'b0;

    // basic load
    push(8'h04);
    drive(1'b1, 8'h04, 1'b0);
    check("load_data", {24'd0, o_data}, 32'h04);
    check("load_int", {31'd0, o_int_tx}, 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    check("busy_int", {31'd0, o_int_tx}, 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    check("busy_data", {24'd0, o_data}, 32'h04);

    // completion then next byte
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    check("idle_int", {31'd0, o_int_tx}, 32'd0);
    push(8'h06);
    drive(1'b1, 8'h06, 1'b0);
    check("next_data", {24'd0, o_data}, 32'h06);
    check("next_int", {31'd0, o_int_tx}, 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);

    // pending buffer with overwrite
    push(8'h04);
    drive(1'b1, 8'h04, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h06, 1'b0);
    drive(1'b1, 8'h07, 1'b0);
    check("pend_hold_int", {31'd0, o_int_tx}, 32'd0);
    check("pend_hold_data", {24'd0, o_data}, 32'h04);
    push(8'h07);
    drive(1'b0, 8'h00, 1'b1);
    check("pend_data", {24'd0, o_data}, 32'h07);
    check("pend_int", {31'd0, o_int_tx}, 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    // simultaneous done_tx and done_alu with pending empty
    push(8'h11);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    push(8'h55);
    drive(1'b1, 8'h55, 1'b1);
    check("simul_data", {24'd0, o_data}, 32'h55);
    check("simul_int", {31'd0, o_int_tx}, 32'd1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);

    // result arriving during START goes to pending
    push(8'h21);
    drive(1'b1, 8'h21, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    check("start_pend_int", {31'd0, o_int_tx}, 32'd0);
    push(8'h22);
    drive(1'b0, 8'h00, 1'b1);
    check("start_pend_data", {24'd0, o_data}, 32'h22);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);

    // done_tx ignored in IDLE and in START
    drive(1'b0, 8'h00, 1'b1);
    check("ign_idle_int", {31'd0, o_int_tx}, 32'd0);
    check("ign_idle_data", {24'd0, o_data}, 32'h22);
    push(8'h33);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    check("ign_start_int", {31'd0, o_int_tx}, 32'd0);
    repeat (2) drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h44, 1'b0);
    check("still_busy_int", {31'd0, o_int_tx}, 32'd0);
    check("still_busy_data", {24'd0, o_data}, 32'h33);
    push(8'h44);
    drive(1'b0, 8'h00, 1'b1);
    check("ign_release_data", {24'd0, o_data}, 32'h44);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);

    // asynchronous reset mid-BUSY drops current and pending bytes
    push(8'h77);
    drive(1'b1, 8'h77, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h78, 1'b0);
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check("async_rst_data", {24'd0, o_data}, 32'h00);
    check("async_rst_int", {31'd0, o_int_tx}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    check("post_rst_int", {31'd0, o_int_tx}, 32'd0);
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    check("post_rst_data", {24'd0, o_data}, 32'h00);

    check("sb_empty", exp_q.size(), 32'd0);
    check("pulse_count", pulses, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interfaz_tx.md
Name: interfaz_tx

Overview:
Glue block between the ALU and the UART transmitter. It captures each ALU result on the ALU's done pulse and presents it on a stable data bus. It then fires a one-cycle start pulse to the transmitter and waits for the transmitter's done before launching another byte. A one-deep pending buffer absorbs a result that arrives while a transmission is in progress.

Parameters:
NB_DATA, 8, width of the ALU result and of the transmitted data word.

Ports:
i_clk  input  1  system clock; all state updates on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_resultado  input  NB_DATA  ALU result; sampled only when i_done_alu=1.
i_done_alu  input  1  one-cycle pulse: i_resultado is valid.
i_done_tx  input  1  one-cycle pulse from the UART TX: current byte finished.
o_data  output  NB_DATA  registered byte for the transmitter. Raw bits; the consumer may interpret them as signed.
o_int_tx  output  1  registered tx-start pulse, exactly one clock wide.

Behaviour:
- Reset (asynchronous, i_rst=1): state=IDLE, o_data=0, o_int_tx=0, pending_valid=0, pending_data=0.
- All outputs come directly from flops. No combinational path from any input to any output.
- FSM states: IDLE, START, BUSY.
- IDLE:
  - If i_done_alu=1 at an edge: o_data<=i_resultado, o_int_tx<=1, go to START.
  - Otherwise hold. i_done_tx is ignored.
- START (lasts exactly one cycle, o_int_tx=1):
  - At the next edge: o_int_tx<=0, go to BUSY.
  - i_done_tx is ignored in this cycle.
  - If i_done_alu=1: pending_data<=i_resultado, pending_valid<=1.
- BUSY (o_int_tx=0, o_data held stable):
  - i_done_alu=1 and i_done_tx=0: capture the result into pending. If pending is already full, overwrite it (latest result wins).
  - i_done_tx=1, pending empty, i_done_alu=0: go to IDLE.
  - i_done_tx=1, pending empty, i_done_alu=1: o_data<=i_resultado, o_int_tx<=1, go to START.
  - i_done_tx=1, pending full: o_data<=pending_data, o_int_tx<=1, go to START. At the same time, pending_valid<=i_done_alu and pending_data<=i_resultado if i_done_alu=1.
- Latency: i_done_alu sampled at edge k (in IDLE) → o_data valid and o_int_tx=1 right after edge k. o_int_tx drops after edge k+1.
- o_data changes only on a load (the same edge that raises o_int_tx). It stays stable for the whole START/BUSY period.
- Minimum spacing between o_int_tx pulses is 2 cycles (START then BUSY).
- Unused state encodings recover to IDLE with o_int_tx=0.
- Reset mid-transmission drops the pending data and the current byte immediately.

Decomposition:
- Shared UART package holds:
  - state encoding constants: IDLE=2'b00, START=2'b01, BUSY=2'b10;
  - the default data width constant (8).
- Single module. No sub-module is needed. The pending buffer is two registers inside the block.

Test Plan:
- Reset: i_rst=1 with random inputs toggling → o_data=0x00, o_int_tx=0. Asserting reset mid-BUSY clears the outputs asynchronously, before the next edge.
- Basic load: release reset; i_resultado=0x04 with a 1-cycle i_done_alu → next edge gives o_data=0x04, o_int_tx=1 for exactly one cycle. Thereafter o_data stays 0x04 and o_int_tx=0.
- Completion and next byte: 1-cycle i_done_tx pulse → state returns to IDLE. Then i_resultado=0x06 with i_done_alu → o_data=0x06 with a single o_int_tx pulse.
- Pending buffer: load 0x04; while BUSY pulse i_done_alu with 0x06, then 0x07 → no o_int_tx yet. On i_done_tx: o_data=0x07 with one o_int_tx pulse; 0x06 is overwritten and never sent.
- Simultaneous events: in BUSY with pending empty, i_done_tx and i_done_alu (0x55) on the same edge → o_data=0x55, o_int_tx pulse, no idle gap.
- Ignored inputs: i_done_tx pulsed in IDLE and in START → no state change, no o_int_tx pulse. The byte from START is still awaiting a real done.
